spi_tx: RTL and testbench

SPI master transmitter that serializes parallel words onto nCS/SCK/MOSI (SPI mode 0, MSB first). It is the initiator-side counterpart to the `spi` slave receiver. A host-side loader uses it to stream instruction words into a target board's `spi`/instruction-memory path. Consecutive words flagged as one burst share a single nCS-low window, so the receiver sees one new_transfer per burst.

---
 rtl/spi_tx.sv | 131 +++++++++++++
 tb/tb_spi_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx.sv
// SPI master transmitter, mode 0 (SCK idles low, data sampled on rising edge),
// MSB first. Words flagged as one burst share a single nCS-low window; a word
// with last=1 closes the burst, followed by a minimum nCS-high gap.
module spi_tx #(
    parameter int width  = 16,
    parameter int clkdiv = 2,
    parameter int csgap  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] data,
    input  logic             valid,
    input  logic             last,
    output logic             ready,
    output logic             busy,
    output logic             nCS,
    output logic             SCK,
    output logic             MOSI
);

    // Bit counter holds 0..width; divider and gap counter hold 0..N-1.
    localparam int BW = $clog2(width) + 1;
    localparam int DW = $clog2(clkdiv) + 1;
    localparam int GW = $clog2(csgap) + 1;

    localparam logic [BW-1:0] BIT_END  = BW'(width);
    localparam logic [DW-1:0] DIV_LAST = DW'(clkdiv - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(csgap - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } state_t;

    state_t            state;
    logic [BW-1:0]     bitcnt;
    logic [DW-1:0]     div;
    logic [GW-1:0]     gcnt;
    // Bits still to be sent after the one currently on MOSI, MSB-aligned.
    logic [width-2:0]  rest;
    logic              last_q;

    // Transmit FSM: word accept, SCK generation, shifting, burst hold and gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= GAP;
            bitcnt <= '0;
            div    <= '0;
            gcnt   <= '0;
            rest   <= '0;
            last_q <= 1'b0;
            nCS    <= 1'b1;
            SCK    <= 1'b0;
            MOSI   <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (valid && ready) begin
                        rest   <= data[width-2:0];
                        MOSI   <= data[width-1];
                        last_q <= last;
                        nCS    <= 1'b0;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        div    <= '0;
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        SCK <= ~SCK;
                        if (!SCK) begin
                            bitcnt <= bitcnt + 1'b1;
                        end else if (bitcnt == BIT_END) begin
                            // Final falling edge: MOSI keeps the last bit.
                            if (last_q) begin
                                state <= HOLD;
                            end else begin
                                state <= WAIT;
                                ready <= 1'b1;
                            end
                        end else begin
                            MOSI <= rest[width-2];
                            rest <= rest << 1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                HOLD: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        nCS   <= 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end

                default: begin
                    nCS   <= 1'b1;
                    SCK   <= 1'b0;
                    ready <= 1'b0;
                    gcnt  <= '0;
                    state <= GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx: timing model derived from accept times, per-cycle output
// compare, a behavioural SPI receiver, and directed word/burst/reset scenarios.
module tb_spi_tx;

    localparam int W = 16;
    localparam int C = 2;
    localparam int G = 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data  = '0;
    logic         valid = 1'b0;
    logic         last  = 1'b0;
    logic         ready, busy, nCS, SCK, MOSI;

    spi_tx #(.width(W), .clkdiv(C), .csgap(G)) dut (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .last(last),
        .ready(ready), .busy(busy), .nCS(nCS), .SCK(SCK), .MOSI(MOSI)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- timing model ----------------
    int           cyc = 0;      // clk edges since reset release
    bit           have = 0;     // a word has been accepted since reset
    int           a = 0;        // edge index of the latest accept
    logic [W-1:0] mw = '0;
    bit           ml = 0;
    int           accepts = 0;

    // Outputs visible after edge t, from the latest accept and the timing rules.
    function automatic void model(input int t, output bit e_ncs, output bit e_sck,
                                  output bit e_mosi, output bit e_ready, output bit e_busy);
        int r, endw, endb;
        if (!have) begin
            e_ncs = 1; e_sck = 0; e_mosi = 0; e_busy = 0; e_ready = (t >= G);
            return;
        end
        r    = t - a;
        endw = 2 * W * C;
        endb = (2 * W + 1) * C;
        if (r < endw) begin
            e_sck   = ((r / C) % 2) == 1;
            e_mosi  = mw[W - 1 - r / (2 * C)];
            e_ncs   = 0;
            e_ready = 0;
            e_busy  = 1;
        end else begin
            e_sck   = 0;
            e_mosi  = mw[0];
            e_ncs   = ml && (r >= endb);
            e_busy  = !ml || (r < endb + G);
            e_ready = ml ? (r >= endb + G) : 1'b1;
        end
    endfunction

    bit pn, ps, pm, pr, pb;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            have = 0;
            cyc  = 0;
        end else begin
            model(cyc, pn, ps, pm, pr, pb);
            cyc++;
            if (valid && pr) begin
                have = 1;
                a    = cyc;
                mw   = data;
                ml   = last;
                accepts++;
            end
        end
    end

    bit en, es, em, er, eb;
    always @(negedge clk) begin
        model(cyc, en, es, em, er, eb);
        check("nCS", nCS, en);
        check("SCK", SCK, es);
        check("MOSI", MOSI, em);
        check("ready", ready, er);
        check("busy", busy, eb);
    end

    // ---------------- behavioural receiver ----------------
    logic [W-1:0] rx_sh = '0;
    int           rx_n = 0;
    logic [W-1:0] rx_q[$];
    int           new_transfers = 0;
    int           ncs_rises = 0;
    int           rises = 0;
    int           viol = 0;
    bit           prev_mosi = 0;

    always @(posedge SCK) begin
        if (nCS === 1'b0) begin
            rx_sh = {rx_sh[W-2:0], MOSI};
            rx_n++;
            rises++;
            if (rx_n == W) begin
                rx_q.push_back(rx_sh);
                rx_n = 0;
            end
        end
    end
    always @(negedge nCS) new_transfers++;
    always @(posedge nCS) begin
        ncs_rises++;
        rx_n = 0;
    end
    always @(negedge clk) begin
        if (SCK === 1'b1 && MOSI !== prev_mosi) viol++;
        prev_mosi = MOSI;
    end

    // ---------------- stimulus ----------------
    task automatic burst(input logic [W-1:0] ws[$]);
        int start, t;
        @(negedge clk);
        for (int i = 0; i < ws.size(); i++) begin
            data  = ws[i];
            last  = (i == ws.size() - 1);
            valid = 1'b1;
            start = accepts;
            t = 0;
            while (accepts == start && t < 1000) begin
                @(negedge clk);
                t++;
            end
            check("accept", accepts - start, 1);
        end
        valid = 1'b0;
        data  = 16'hDEAD;
        last  = 1'b0;
    endtask

    task automatic wait_idle();
        bit n, s, m, rd, b;
        int t;
        t = 0;
        model(cyc, n, s, m, rd, b);
        while (!(rd && !b) && t < 2000) begin
            @(negedge clk);
            t++;
            model(cyc, n, s, m, rd, b);
        end
        check("idle_reached", (rd && !b), 1);
    endtask

    logic [W-1:0] q[$];
    int r0, nt0, nr0, acc0, k, j, t;
    bit xn, xs, xm, xr, xb;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_nCS", nCS, 1);
        check("rst_SCK", SCK, 0);
        check("rst_MOSI", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_rel_1", ready, 0);
        @(negedge clk);
        check("ready_rel_2", ready, 1);

        // Single word with last.
        r0 = rises;
        q = '{16'hA5C3};
        burst(q);
        k = 0;
        while (nCS == 1'b0 && k < 200) begin @(negedge clk); k++; end
        check("single_ncs_low_cycles", k, 66);
        j = 0;
        while (!ready && j < 50) begin @(negedge clk); j++; end
        check("single_ready_after_ncs", j, 2);
        check("single_rises", rises - r0, 16);
        check("single_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("single_word", rx_q.pop_front(), 16'hA5C3);

        // Three-word burst with valid held.
        wait_idle();
        r0 = rises; nt0 = new_transfers; nr0 = ncs_rises;
        q = '{16'h0001, 16'h8000, 16'hFFFF};
        burst(q);
        wait_idle();
        check("burst_rises", rises - r0, 48);
        check("burst_new_transfer", new_transfers - nt0, 1);
        check("burst_ncs_rises", ncs_rises - nr0, 1);
        check("burst_rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("burst_w0", rx_q.pop_front(), 16'h0001);
            check("burst_w1", rx_q.pop_front(), 16'h8000);
            check("burst_w2", rx_q.pop_front(), 16'hFFFF);
        end
        rx_q.delete();

        // Loopback-style burst.
        nt0 = new_transfers;
        q = '{16'h1234, 16'hBEEF};
        burst(q);
        wait_idle();
        check("loop_new_transfer", new_transfers - nt0, 1);
        check("loop_data_ready", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("loop_w0", rx_q.pop_front(), 16'h1234);
            check("loop_w1", rx_q.pop_front(), 16'hBEEF);
        end
        rx_q.delete();

        // Asynchronous reset after 7 rising edges.
        r0 = rises;
        q = '{16'hFFFF};
        burst(q);
        t = 0;
        while (rises - r0 < 7 && t < 500) begin @(negedge clk); t++; end
        check("abort_rises", rises - r0, 7);
        #2 reset = 1'b1;
        #1;
        check("abort_nCS", nCS, 1);
        check("abort_SCK", SCK, 0);
        check("abort_MOSI", MOSI, 0);
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_dropped", rx_q.size(), 0);
        wait_idle();
        q = '{16'h00FF};
        burst(q);
        wait_idle();
        check("after_abort_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("after_abort_word", rx_q.pop_front(), 16'h00FF);
        rx_q.delete();

        // Data changing while not ready, and right after accept.
        acc0 = accepts;
        q = '{16'h1111};
        burst(q);
        valid = 1'b1;
        last  = 1'b1;
        t = 0;
        while (accepts == acc0 + 1 && t < 500) begin
            model(cyc, xn, xs, xm, xr, xb);
            data = xr ? 16'h5A3C : W'($urandom);
            @(negedge clk);
            t++;
        end
        valid = 1'b0;
        data  = 16'hC0DE;
        wait_idle();
        check("hold_accepts", accepts - acc0, 2);
        check("hold_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("hold_w0", rx_q.pop_front(), 16'h1111);
            check("hold_w1", rx_q.pop_front(), 16'h5A3C);
        end

        check("mosi_stable_while_sck_high", viol, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
